// File: rtl/log_reader.sv
// Drain side of the attestation log RAM: fetches records behind the writer,
// decodes them onto a valid/ready stream and flags writer laps and bad types.
module log_reader #(
  parameter int RAM_LAT = 1,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              we,
  input  logic              clr_ram,
  output logic              re,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [36:0]       rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_type,
  output logic [15:0]       out_pc,
  output logic [15:0]       out_addr,
  output logic              out_en,
  output logic              out_wr,
  output logic [ADDR_W-1:0] pending,
  output logic              overflow,
  output logic              bad_type
);

  // state   | meaning
  // IDLE    | nothing in flight, waiting for pending != 0
  // FETCH   | re pulse at rd_ptr, pointer advances
  // WAIT    | RAM latency countdown, capture at terminal count
  // PRESENT | record offered until out_valid & out_ready
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PRESENT} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(RAM_LAT - 1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_next;
  logic [1:0]        wait_cnt;
  logic              fetch;
  logic              wait_done;
  logic              good_type;
  logic              lap;

  assign pending   = wr_addr - rd_ptr;
  assign wr_next   = wr_addr + 1'b1;
  assign fetch     = (state == FETCH);
  assign wait_done = (state == WAIT) && (wait_cnt == 2'd0);
  assign good_type = (rd_data[36:34] <= 3'd5);
  // A fetch already moves rd_ptr past the slot the writer is about to hit.
  assign lap       = we && (wr_next == rd_ptr) && !fetch;

  assign re        = rst_n && !clr_ram && fetch;
  assign rd_addr   = re ? rd_ptr : '0;
  assign out_valid = (state == PRESENT);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pending != '0) next_state = FETCH;
      FETCH:   next_state = WAIT;
      WAIT:    if (wait_cnt == 2'd0) next_state = good_type ? PRESENT : IDLE;
      PRESENT: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (clr_ram) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wait_cnt <= '0;
      overflow <= 1'b0;
      bad_type <= 1'b0;
      out_type <= '0;
      out_pc   <= '0;
      out_addr <= '0;
      out_en   <= 1'b0;
      out_wr   <= 1'b0;
    end else if (clr_ram) begin
      rd_ptr   <= '0;
      wait_cnt <= '0;
      overflow <= 1'b0;
      bad_type <= 1'b0;
    end else begin
      if (fetch || lap) rd_ptr <= rd_ptr + 1'b1;
      if (lap) overflow <= 1'b1;

      if (fetch)                               wait_cnt <= LAT_LOAD;
      else if (state == WAIT && wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;

      if (wait_done) begin
        out_type <= rd_data[36:34];
        out_pc   <= rd_data[33:18];
        out_addr <= rd_data[17:2];
        out_en   <= rd_data[1];
        out_wr   <= rd_data[0];
        if (!good_type) bad_type <= 1'b1;
      end
    end
  end

endmodule
